// File: rtl/mips_mc_ctrl_if.sv
// Control/handshake bundle between the multi-cycle sequencer (master) and
// the datapath plus instruction/data memories (slave).
interface mips_mc_ctrl_if;
    logic       run;
    logic [2:0] opcode;
    logic [3:0] funct;
    logic       zero;
    logic       imem_ack;
    logic       dmem_ack;
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       ir_we;
    logic       pc_we;
    logic       reg_we;
    logic [1:0] pc_src;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src;
    logic [1:0] alu_op;
    logic [3:0] state;
    logic       instr_done;

    modport master (
        input  run, opcode, funct, zero, imem_ack, dmem_ack,
        output imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we,
               pc_src, reg_dst, mem_to_reg, alu_src, alu_op, state, instr_done
    );

    modport slave (
        output run, opcode, funct, zero, imem_ack, dmem_ack,
        input  imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we,
               pc_src, reg_dst, mem_to_reg, alu_src, alu_op, state, instr_done
    );
endinterface

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle control sequencer for the 16-bit MIPS datapath.
// Define MC_CTRL_PERF_EN to add the cycle_cnt / retire_cnt performance counters.
module mips_mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    mips_mc_ctrl_if.master    bus
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  retire_cnt
`endif
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC     = 4'd3,
        S_ALU_WB   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WB   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10
    } state_t;

    localparam logic [2:0] OP_R    = 3'b000;
    localparam logic [2:0] OP_SLTI = 3'b001;
    localparam logic [2:0] OP_J    = 3'b010;
    localparam logic [2:0] OP_JAL  = 3'b011;
    localparam logic [2:0] OP_LW   = 3'b100;
    localparam logic [2:0] OP_SW   = 3'b101;
    localparam logic [2:0] OP_BEQ  = 3'b110;
    localparam logic [2:0] OP_ADDI = 3'b111;

    localparam logic [3:0] FN_JR   = 4'b1000;

    state_t     state_q, state_d;
    state_t     boundary_next;
    logic       is_jr;
    logic [1:0] exec_alu_op;
    logic       exec_alu_src;

    logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, alu_src, instr_done;
    logic [1:0] pc_src, reg_dst, mem_to_reg, alu_op;

    assign is_jr         = (bus.opcode == OP_R) && (bus.funct == FN_JR);
    assign boundary_next = bus.run ? S_FETCH : S_IDLE;

    // ALU setup shared by EXEC and ALU_WB so the result stays stable for write-back
    always_comb begin
        exec_alu_op  = 2'b00;
        exec_alu_src = 1'b0;
        case (bus.opcode)
            OP_R:    exec_alu_op = 2'b10;
            OP_ADDI: exec_alu_src = 1'b1;
            OP_SLTI: begin
                exec_alu_op  = 2'b11;
                exec_alu_src = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        reg_we     = 1'b0;
        pc_src     = 2'b00;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        alu_src    = 1'b0;
        alu_op     = 2'b00;
        instr_done = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.run) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (bus.imem_ack) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (bus.opcode)
                    OP_R:            state_d = is_jr ? S_JUMP : S_EXEC;
                    OP_ADDI, OP_SLTI: state_d = S_EXEC;
                    OP_LW, OP_SW:    state_d = S_MEM_ADDR;
                    OP_BEQ:          state_d = S_BRANCH;
                    default:         state_d = S_JUMP;
                endcase
            end
            S_EXEC: begin
                alu_op  = exec_alu_op;
                alu_src = exec_alu_src;
                state_d = S_ALU_WB;
            end
            S_ALU_WB: begin
                alu_op     = exec_alu_op;
                alu_src    = exec_alu_src;
                reg_we     = 1'b1;
                reg_dst    = (bus.opcode == OP_R) ? 2'b01 : 2'b00;
                pc_we      = 1'b1;
                instr_done = 1'b1;
                state_d    = boundary_next;
            end
            S_MEM_ADDR: begin
                alu_src = 1'b1;
                state_d = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                dmem_req = 1'b1;
                alu_src  = 1'b1;
                if (bus.dmem_ack) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_we     = 1'b1;
                mem_to_reg = 2'b01;
                pc_we      = 1'b1;
                instr_done = 1'b1;
                state_d    = boundary_next;
            end
            S_MEM_WR: begin
                dmem_req = 1'b1;
                dmem_we  = 1'b1;
                alu_src  = 1'b1;
                if (bus.dmem_ack) begin
                    pc_we      = 1'b1;
                    instr_done = 1'b1;
                    state_d    = boundary_next;
                end
            end
            S_BRANCH: begin
                alu_op     = 2'b01;
                pc_we      = 1'b1;
                pc_src     = bus.zero ? 2'b01 : 2'b00;
                instr_done = 1'b1;
                state_d    = boundary_next;
            end
            S_JUMP: begin
                pc_we      = 1'b1;
                instr_done = 1'b1;
                state_d    = boundary_next;
                case (bus.opcode)
                    OP_J:    pc_src = 2'b10;
                    OP_JAL: begin
                        pc_src     = 2'b10;
                        reg_we     = 1'b1;
                        reg_dst    = 2'b10;
                        mem_to_reg = 2'b10;
                    end
                    default: pc_src = 2'b11;
                endcase
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode from state_q, so the async reset forces them all low at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    assign bus.imem_req   = imem_req;
    assign bus.dmem_req   = dmem_req;
    assign bus.dmem_we    = dmem_we;
    assign bus.ir_we      = ir_we;
    assign bus.pc_we      = pc_we;
    assign bus.reg_we     = reg_we;
    assign bus.pc_src     = pc_src;
    assign bus.reg_dst    = reg_dst;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.alu_src    = alu_src;
    assign bus.alu_op     = alu_op;
    assign bus.state      = state_q;
    assign bus.instr_done = instr_done;

`ifdef MC_CTRL_PERF_EN
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

    always_comb begin
        cycle_cnt_d  = cycle_cnt_q + CNT_W'(state_q != S_IDLE);
        retire_cnt_d = retire_cnt_q + CNT_W'(instr_done);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_q  <= '0;
            retire_cnt_q <= '0;
        end else begin
            cycle_cnt_q  <= cycle_cnt_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign cycle_cnt  = cycle_cnt_q;
    assign retire_cnt = retire_cnt_q;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule
